// File: rtl/inst_fetch_mod.sv
// rtl/inst_fetch_mod.sv - instruction prefetch FIFO between memory arbiter and control_unit_mod
// Optional CB-prefix pulse generation enabled by defining INST_FETCH_CB_DETECT_EN.
module inst_fetch_mod #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_consume,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  inst_buffer,
  output logic        inst_valid,
  output logic [15:0] inst_pc,
  output logic        toggle_cb
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DISCARD} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_mem_req;
  logic               w_next_req;
  logic [15:0]        r_mem_addr;
  logic [15:0]        w_next_addr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_post;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [15:0]        r_fetch_pc;
  logic [15:0]        r_head_pc;
  logic [7:0]         r_fifo [FIFO_DEPTH];
  logic               w_push;
  logic               w_pop;

  // A redirect suppresses both the write of in-flight data and any pop in the same cycle.
  assign w_push       = (r_state == S_FETCH) && mem_ack && !pc_load;
  assign w_pop        = inst_consume && (r_count != '0) && !pc_load;
  assign w_count_post = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else begin
      r_state    <= w_next_state;
      r_mem_req  <= w_next_req;
      r_mem_addr <= w_next_addr;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_req   = r_mem_req;
    w_next_addr  = r_mem_addr;
    case (r_state)
      S_IDLE: begin
        if (!pc_load && (r_count < FULL)) begin
          w_next_state = S_FETCH;
          w_next_req   = 1'b1;
          w_next_addr  = r_fetch_pc;
        end
      end
      S_FETCH: begin
        if (pc_load) begin
          if (mem_ack) begin
            w_next_state = S_IDLE;
            w_next_req   = 1'b0;
          end else begin
            w_next_state = S_DISCARD;
          end
        end else if (mem_ack) begin
          if (w_count_post < FULL) begin
            w_next_addr = r_fetch_pc + 16'd1;
          end else begin
            w_next_state = S_IDLE;
            w_next_req   = 1'b0;
          end
        end
      end
      S_DISCARD: begin
        // The bus read cannot be cancelled; wait it out and drop its data.
        if (mem_ack) begin
          w_next_state = S_IDLE;
          w_next_req   = 1'b0;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_req   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fetch_pc <= RESET_PC;
      r_head_pc  <= RESET_PC;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= 8'h00;
    end else if (pc_load) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fetch_pc <= pc_load_value;
      r_head_pc  <= pc_load_value;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_rdata;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
        r_fetch_pc       <= r_fetch_pc + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_head_pc <= r_head_pc + 16'd1;
      end
      r_count <= w_count_post;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign inst_valid  = (r_count != '0);
  assign inst_buffer = inst_valid ? r_fifo[r_rd_ptr] : 8'h00;
  assign inst_pc     = r_head_pc;

`ifdef INST_FETCH_CB_DETECT_EN
  logic r_toggle_cb;
  logic r_after_cb;

  // r_after_cb marks that the next pop is the CB-table opcode, which never pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_toggle_cb <= 1'b0;
      r_after_cb  <= 1'b0;
    end else begin
      r_toggle_cb <= w_pop && (inst_buffer == 8'hCB) && !r_after_cb;
      if (pc_load) r_after_cb <= 1'b0;
      else if (w_pop) r_after_cb <= (inst_buffer == 8'hCB) && !r_after_cb;
    end
  end

  assign toggle_cb = r_toggle_cb;
`else
  assign toggle_cb = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_mod.sv
// tb/tb_inst_fetch_mod.sv - self-checking bench for inst_fetch_mod
// Reference model tracks bytes-in-flight, head/fetch addresses and CB-prefix rule at stream level.
module tb_inst_fetch_mod;

  logic        clock;
  logic        reset;
  logic        inst_consume;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  inst_buffer;
  logic        inst_valid;
  logic [15:0] inst_pc;
  logic        toggle_cb;

  inst_fetch_mod #(.FIFO_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .inst_consume(inst_consume), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .inst_buffer(inst_buffer),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .toggle_cb(toggle_cb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int          n;
  logic [15:0] exp_head;
  logic [15:0] exp_fetch;
  bit          stale;
  bit          after_cb;
  bit          exp_tog;
  bit          cb_en;
  int          wcnt;
  int          mem_waits;
  bit          rand_waits;
  bit          prev_out;
  logic [15:0] prev_addr;

  function automatic logic [7:0] memf(input logic [15:0] a);
    if (a == 16'h0300) return 8'hCB;
    if (a == 16'h0301) return 8'h37;
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit cons, input bit ld, input logic [15:0] val);
    bit acc;
    bit pop;
    chk("inst_valid", 32'(inst_valid), 32'(n != 0));
    chk("inst_pc", 32'(inst_pc), 32'(exp_head));
    chk("inst_buffer", 32'(inst_buffer), (n != 0) ? 32'(memf(exp_head)) : 32'h0);
    chk("toggle_cb", 32'(toggle_cb), 32'(exp_tog));
    if (prev_out) begin
      chk("req_hold", 32'(mem_req), 32'h1);
      chk("addr_hold", 32'(mem_addr), 32'(prev_addr));
    end
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    if (mem_req === 1'b1) begin
      if (wcnt >= mem_waits) begin
        mem_ack = 1'b1;
        mem_rdata = memf(mem_addr);
        wcnt = 0;
        if (rand_waits) mem_waits = $urandom_range(0, 3);
      end else begin
        wcnt++;
      end
    end
    inst_consume = cons;
    pc_load = ld;
    pc_load_value = val;
    prev_out = mem_req && !mem_ack;
    prev_addr = mem_addr;
    acc = mem_req && mem_ack && !ld && !stale;
    pop = cons && (n != 0) && !ld;
    if (acc) chk("fetch_addr", 32'(mem_addr), 32'(exp_fetch));
    exp_tog = cb_en && pop && (memf(exp_head) == 8'hCB) && !after_cb;
    if (ld) begin
      n = 0;
      exp_head = val;
      exp_fetch = val;
      stale = mem_req && !mem_ack;
      after_cb = 1'b0;
    end else begin
      if (mem_req && mem_ack) stale = 1'b0;
      if (acc) begin
        n++;
        exp_fetch++;
      end
      if (pop) begin
        after_cb = (memf(exp_head) == 8'hCB) && !after_cb;
        n--;
        exp_head++;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef INST_FETCH_CB_DETECT_EN
    cb_en = 1'b1;
`else
    cb_en = 1'b0;
`endif
    reset = 1'b0;
    inst_consume = 1'b0;
    pc_load = 1'b0;
    pc_load_value = 16'h0000;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    n = 0; exp_head = 16'h0000; exp_fetch = 16'h0000;
    stale = 0; after_cb = 0; exp_tog = 0;
    wcnt = 0; mem_waits = 0; rand_waits = 0; prev_out = 0; prev_addr = 16'h0000;

    repeat (2) @(negedge clock);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_buffer", 32'(inst_buffer), 32'h00);
    chk("rst_pc", 32'(inst_pc), 32'h0000);
    chk("rst_toggle", 32'(toggle_cb), 32'h0);
    reset = 1'b1;

    cycle(0, 0, 16'h0);
    chk("lat_req", 32'(mem_req), 32'h1);
    chk("lat_valid_c1", 32'(inst_valid), 32'h0);
    cycle(0, 0, 16'h0);
    chk("lat_valid_c2", 32'(inst_valid), 32'h1);
    repeat (4) cycle(0, 0, 16'h0);
    chk("fill_req_off", 32'(mem_req), 32'h0);
    chk("fill_buf", 32'(inst_buffer), 32'h00);
    chk("fill_pc", 32'(inst_pc), 32'h0000);

    repeat (12) cycle(1, 0, 16'h0);

    mem_waits = 3;
    for (int i = 0; i < 40 && !(mem_req === 1'b1 && wcnt >= 1 && wcnt < mem_waits); i++)
      cycle(1, 0, 16'h0);
    chk("redir_setup", 32'(mem_req), 32'h1);
    cycle(0, 1, 16'h0150);
    chk("redir_req_held", 32'(mem_req), 32'h1);
    chk("redir_valid", 32'(inst_valid), 32'h0);
    chk("redir_pc", 32'(inst_pc), 32'h0150);
    for (int i = 0; i < 20 && mem_req === 1'b1; i++) cycle(0, 0, 16'h0);
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) cycle(0, 0, 16'h0);
    chk("redir_new_req", 32'(mem_req), 32'h1);
    chk("redir_addr", 32'(mem_addr), 32'h0150);
    mem_waits = 0;
    repeat (8) cycle(1, 0, 16'h0);

    cycle(0, 1, 16'hFFFF);
    repeat (6) cycle(0, 0, 16'h0);
    chk("wrap_pc_ffff", 32'(inst_pc), 32'hFFFF);
    cycle(1, 0, 16'h0);
    chk("wrap_pc_0000", 32'(inst_pc), 32'h0000);
    chk("wrap_buf", 32'(inst_buffer), 32'h00);
    repeat (4) cycle(1, 0, 16'h0);

    cycle(1, 1, 16'h0200);
    cycle(1, 0, 16'h0);
    chk("empty_pc", 32'(inst_pc), 32'h0200);
    repeat (6) cycle(0, 0, 16'h0);
    cycle(1, 1, 16'h0210);
    chk("ld_wins_valid", 32'(inst_valid), 32'h0);
    chk("ld_wins_pc", 32'(inst_pc), 32'h0210);

    cycle(0, 1, 16'h0300);
    repeat (6) cycle(0, 0, 16'h0);
    cycle(1, 0, 16'h0);
    chk("cb_pulse", 32'(toggle_cb), 32'(cb_en));
    cycle(1, 0, 16'h0);
    chk("cb_no_pulse", 32'(toggle_cb), 32'h0);
    repeat (3) cycle(1, 0, 16'h0);

    rand_waits = 1;
    for (int i = 0; i < 800; i++) begin
      logic [15:0] v;
      bit ld;
      ld = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom);
      if ($urandom_range(0, 9) == 0) v = 16'h0300;
      cycle($urandom_range(0, 9) < 7, ld, v);
    end

    rand_waits = 0;
    mem_waits = 3;
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) cycle(1, 0, 16'h0);
    chk("midtx_setup", 32'(mem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("midtx_req_drop", 32'(mem_req), 32'h0);
    chk("midtx_addr", 32'(mem_addr), 32'h0000);
    chk("midtx_valid", 32'(inst_valid), 32'h0);
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
